sal_cmd_sched: RTL
==================

# sal_cmd_sched

Per-channel command scheduler; the responder side of the bank-controller request/grant interface. Collects one `bk_req_t` per bank, enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW), grants at most one command per cycle through `bk_gnt_t`, and issues the granted command on a registered DRAM command port. Sits between the per-bank controllers and the DDR PHY command path.

## Interface
- `NUM_BANKS`, default 4: number of bank controllers served; power of two, range 2..16.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `timing_if`  TIMING_IF.MON  —  supplies `t_rrd_m1`, `t_ccd_m1`, `t_wtr_m1`, `t_rtw_m1`
- `bk_reqs_i`  in  `bk_req_t [NUM_BANKS]`  per-bank act/rd/wr/pre/ref request plus ra/ca/id/len/seq_num
- `bk_gnts_o`  out  `bk_gnt_t [NUM_BANKS]`  per-bank act/rd/wr/pre/ref grant
- `cmd_valid_o`  out  1  command issued this cycle
- `cmd_o`  out  `dram_cmd_t`  NOP/ACT/RD/WR/PRE/REF
- `cmd_ba_o`  out  `$clog2(NUM_BANKS)`  target bank
- `cmd_ra_o`, `cmd_ca_o`, `cmd_id_o`, `cmd_len_o`  out  `dram_ra_t`/`dram_ca_t`/`axi_id_t`/`axi_len_t`  granted request fields

## Operation
- Grants are combinational from `bk_reqs_i` and registered state; same-cycle grant, as the bank controller samples grants in its request cycle.
- Exactly zero or one grant bit set across all banks and all fields per cycle.
- Class priority: CAS (rd/wr) > ACT > PRE > REF.
- Eligibility: CAS needs `ccd_cnt==0`, RD additionally `wtr_cnt==0`, WR additionally `rtw_cnt==0`; ACT needs `rrd_cnt==0`; PRE and REF always eligible (per-bank constraints enforced by the bank controller).
- Within a class: round-robin over banks starting at that class's pointer; first eligible requesting bank wins. RD and WR share the CAS pointer; a WR blocked by tRTW is skipped, not waited on.
- On grant, class pointer <= granted bank + 1, wrapping mod `NUM_BANKS`. Pointers of other classes unchanged.
- A bank asserting more than one req bit in one cycle is a protocol error; assertion fires, highest-priority bit is served.
- Counters (saturating down-counters, load on grant, decrement to 0):
  - ACT grant: `rrd_cnt <= t_rrd_m1`
  - RD grant: `ccd_cnt <= t_ccd_m1`, `rtw_cnt <= t_rtw_m1`
  - WR grant: `ccd_cnt <= t_ccd_m1`, `wtr_cnt <= t_wtr_m1`
- Command port: on a grant, the next cycle drives `cmd_valid_o=1` and the granted type/bank/fields; otherwise `cmd_valid_o=0`, `cmd_o=NOP`, and the fields hold their last value.

## Timing
- Grant-to-command latency: 1 cycle.
- With `tX_m1 = N-1`, the earliest following command of the same constraint is granted N cycles after the first grant.
- `tX_m1 = 0`: back-to-back grants allowed.
- Reset (async, any time): counters 0, pointers 0, `cmd_valid_o=0`, `cmd_o=NOP`, all other command outputs 0. Grants are all 0 while `rst_n=0`. A grant in progress is dropped and no command is issued.
- Idle (no requests): all grants 0, counters keep decrementing.

## Structure
- Shared package `SAL_DDR_PARAMS`: `dram_cmd_t` enum (NOP=0, ACT, RD, WR, PRE, REF), timing widths `T_RRD_WIDTH`, `T_CCD_WIDTH`, `T_WTR_WIDTH`, `T_RTW_WIDTH`. Add the four `_m1` fields to `TIMING_IF` if they are missing.
- One sub-module, `sal_rr_arb`: parameterised NUM round-robin arbiter with `req` vector, `ptr` in, one-hot `gnt` out. Instantiated once per class (4 instances).
- Counters inline, with async reset.

## Test plan
- Single ACT, bank 2, cycle 10 -> `bk_gnts_o[2].act_gnt=1` at cycle 10; cycle 11 `cmd_valid_o=1`, `cmd_o=ACT`, `cmd_ba_o=2`, `cmd_ra_o` equals the requested ra.
- Banks 0–3 hold RD, `t_ccd_m1=3` -> grants at cycles 0, 4, 8, 12 to banks 0, 1, 2, 3; pointer wraps, so bank 0 is granted again at cycle 16.
- Bank 0 RD and bank 1 ACT in the same cycle, counters 0 -> bank 0 RD granted. The ACT is granted the next cycle, because it is the only eligible class.
- WR at cycle 0 (`t_wtr_m1=5`, `t_ccd_m1=1`), then RD from bank 1 pending -> RD granted at cycle 6, not 2.
- RD at cycle 0 (`t_rtw_m1=4`), then bank 2 WR and bank 3 RD pending at cycle 2 -> bank 3 RD is granted when `ccd_cnt` reaches 0, skipping the blocked WR. The WR is granted no earlier than cycle 5.
- Assert `rst_n=0` mid-cycle, right after an ACT grant -> outputs go to reset values immediately, no command is issued. After release, ACT is grantable without tRRD wait.

Source files
------------

// File: rtl/sal_cmd_sched_pkg.sv
// Shared DDR scheduler types: DRAM command encoding, timing widths,
// and the bank-controller request/grant bundles.
package SAL_DDR_PARAMS;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } dram_cmd_t;

  localparam int T_RRD_WIDTH = 4;
  localparam int T_CCD_WIDTH = 4;
  localparam int T_WTR_WIDTH = 4;
  localparam int T_RTW_WIDTH = 4;

  localparam int RA_WIDTH  = 16;
  localparam int CA_WIDTH  = 10;
  localparam int ID_WIDTH  = 4;
  localparam int LEN_WIDTH = 8;
  localparam int SEQ_WIDTH = 8;

  typedef logic [RA_WIDTH-1:0]  dram_ra_t;
  typedef logic [CA_WIDTH-1:0]  dram_ca_t;
  typedef logic [ID_WIDTH-1:0]  axi_id_t;
  typedef logic [LEN_WIDTH-1:0] axi_len_t;
  typedef logic [SEQ_WIDTH-1:0] seq_num_t;

  typedef struct packed {
    logic     act_req;
    logic     rd_req;
    logic     wr_req;
    logic     pre_req;
    logic     ref_req;
    dram_ra_t ra;
    dram_ca_t ca;
    axi_id_t  id;
    axi_len_t len;
    seq_num_t seq_num;
  } bk_req_t;

  typedef struct packed {
    logic act_gnt;
    logic rd_gnt;
    logic wr_gnt;
    logic pre_gnt;
    logic ref_gnt;
  } bk_gnt_t;

endpackage

// File: rtl/sal_timing_if.sv
// Channel timing parameters (minus one), driven by configuration logic
// and monitored by the command scheduler.
interface TIMING_IF;
  import SAL_DDR_PARAMS::*;

  logic [T_RRD_WIDTH-1:0] t_rrd_m1;
  logic [T_CCD_WIDTH-1:0] t_ccd_m1;
  logic [T_WTR_WIDTH-1:0] t_wtr_m1;
  logic [T_RTW_WIDTH-1:0] t_rtw_m1;

  modport MON (
    input t_rrd_m1,
    input t_ccd_m1,
    input t_wtr_m1,
    input t_rtw_m1
  );
endinterface

// File: rtl/sal_cmd_sched_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins,
// wrapping modulo NUM (NUM is a power of two).
module sal_rr_arb #(
  parameter int NUM = 4
) (
  input  logic [NUM-1:0]         req,
  input  logic [$clog2(NUM)-1:0] ptr,
  output logic [NUM-1:0]         gnt
);
  localparam int PW = $clog2(NUM);

  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM; i++) begin
      idx = ptr + PW'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// Per-channel DRAM command scheduler: one grant per cycle across banks,
// inter-bank timing enforcement, registered command port.
module sal_cmd_sched
  import SAL_DDR_PARAMS::*;
#(
  parameter int NUM_BANKS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  TIMING_IF.MON                        timing_if,
  input  bk_req_t                      bk_reqs_i [NUM_BANKS],
  output bk_gnt_t                      bk_gnts_o [NUM_BANKS],
  output logic                         cmd_valid_o,
  output dram_cmd_t                    cmd_o,
  output logic [$clog2(NUM_BANKS)-1:0] cmd_ba_o,
  output dram_ra_t                     cmd_ra_o,
  output dram_ca_t                     cmd_ca_o,
  output axi_id_t                      cmd_id_o,
  output axi_len_t                     cmd_len_o
);
  localparam int BW = $clog2(NUM_BANKS);
  typedef logic [BW-1:0] ba_t;

  logic [NUM_BANKS-1:0] rd_v, wr_v, act_v, pre_v, ref_v;
  logic [NUM_BANKS-1:0] cas_req, act_req;
  logic [NUM_BANKS-1:0] cas_g, act_g, pre_g, ref_g;
  logic [NUM_BANKS-1:0] gnt_vec;
  logic [NUM_BANKS-1:0] unused_seq;
  ba_t                  cas_ptr, act_ptr, pre_ptr, ref_ptr;
  ba_t                  gnt_ba;
  dram_cmd_t            gnt_cmd;
  logic                 rd_ok, wr_ok, act_ok;
  logic                 cas_sel, act_sel, pre_sel, ref_sel;

  logic [T_RRD_WIDTH-1:0] rrd_cnt;
  logic [T_CCD_WIDTH-1:0] ccd_cnt;
  logic [T_WTR_WIDTH-1:0] wtr_cnt;
  logic [T_RTW_WIDTH-1:0] rtw_cnt;

  // A bank raising several req bits keeps only its highest-priority one
  always_comb begin
    rd_v       = '0;
    wr_v       = '0;
    act_v      = '0;
    pre_v      = '0;
    ref_v      = '0;
    unused_seq = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_v[b]  = bk_reqs_i[b].rd_req;
      wr_v[b]  = bk_reqs_i[b].wr_req & ~rd_v[b];
      act_v[b] = bk_reqs_i[b].act_req & ~(rd_v[b] | wr_v[b]);
      pre_v[b] = bk_reqs_i[b].pre_req
               & ~(rd_v[b] | wr_v[b] | act_v[b]);
      ref_v[b] = bk_reqs_i[b].ref_req
               & ~(rd_v[b] | wr_v[b] | act_v[b] | pre_v[b]);
      unused_seq[b] = ^bk_reqs_i[b].seq_num;
    end
  end

  assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);
  assign act_ok = (rrd_cnt == '0);

  assign cas_req = (rd_v & {NUM_BANKS{rd_ok}})
                 | (wr_v & {NUM_BANKS{wr_ok}});
  assign act_req = act_v & {NUM_BANKS{act_ok}};

  sal_rr_arb #(.NUM(NUM_BANKS)) u_cas_arb (
    .req(cas_req), .ptr(cas_ptr), .gnt(cas_g));
  sal_rr_arb #(.NUM(NUM_BANKS)) u_act_arb (
    .req(act_req), .ptr(act_ptr), .gnt(act_g));
  sal_rr_arb #(.NUM(NUM_BANKS)) u_pre_arb (
    .req(pre_v), .ptr(pre_ptr), .gnt(pre_g));
  sal_rr_arb #(.NUM(NUM_BANKS)) u_ref_arb (
    .req(ref_v), .ptr(ref_ptr), .gnt(ref_g));

  assign cas_sel = rst_n && (|cas_g);
  assign act_sel = rst_n && !(|cas_g) && (|act_g);
  assign pre_sel = rst_n && !(|{cas_g, act_g}) && (|pre_g);
  assign ref_sel = rst_n && !(|{cas_g, act_g, pre_g}) && (|ref_g);

  always_comb begin
    gnt_vec = '0;
    gnt_cmd = NOP;
    unique case (1'b1)
      cas_sel: begin
        gnt_vec = cas_g;
        gnt_cmd = (|(cas_g & rd_v)) ? RD : WR;
      end
      act_sel: begin
        gnt_vec = act_g;
        gnt_cmd = ACT;
      end
      pre_sel: begin
        gnt_vec = pre_g;
        gnt_cmd = PRE;
      end
      ref_sel: begin
        gnt_vec = ref_g;
        gnt_cmd = REF;
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt_ba = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bk_gnts_o[b]         = '0;
      bk_gnts_o[b].act_gnt = gnt_vec[b] && (gnt_cmd == ACT);
      bk_gnts_o[b].rd_gnt  = gnt_vec[b] && (gnt_cmd == RD);
      bk_gnts_o[b].wr_gnt  = gnt_vec[b] && (gnt_cmd == WR);
      bk_gnts_o[b].pre_gnt = gnt_vec[b] && (gnt_cmd == PRE);
      bk_gnts_o[b].ref_gnt = gnt_vec[b] && (gnt_cmd == REF);
      if (gnt_vec[b]) gnt_ba = gnt_ba | ba_t'(b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      wtr_cnt <= '0;
      rtw_cnt <= '0;
    end else begin
      if (gnt_cmd == ACT)
        rrd_cnt <= timing_if.t_rrd_m1;
      else if (rrd_cnt != '0)
        rrd_cnt <= rrd_cnt - T_RRD_WIDTH'(1);
      if (gnt_cmd == RD || gnt_cmd == WR)
        ccd_cnt <= timing_if.t_ccd_m1;
      else if (ccd_cnt != '0)
        ccd_cnt <= ccd_cnt - T_CCD_WIDTH'(1);
      if (gnt_cmd == WR)
        wtr_cnt <= timing_if.t_wtr_m1;
      else if (wtr_cnt != '0)
        wtr_cnt <= wtr_cnt - T_WTR_WIDTH'(1);
      if (gnt_cmd == RD)
        rtw_cnt <= timing_if.t_rtw_m1;
      else if (rtw_cnt != '0)
        rtw_cnt <= rtw_cnt - T_RTW_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cas_ptr <= '0;
      act_ptr <= '0;
      pre_ptr <= '0;
      ref_ptr <= '0;
    end else begin
      if (cas_sel) cas_ptr <= gnt_ba + ba_t'(1);
      if (act_sel) act_ptr <= gnt_ba + ba_t'(1);
      if (pre_sel) pre_ptr <= gnt_ba + ba_t'(1);
      if (ref_sel) ref_ptr <= gnt_ba + ba_t'(1);
    end
  end

  // Fields hold their last value on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_o <= 1'b0;
      cmd_o       <= NOP;
      cmd_ba_o    <= '0;
      cmd_ra_o    <= '0;
      cmd_ca_o    <= '0;
      cmd_id_o    <= '0;
      cmd_len_o   <= '0;
    end else begin
      cmd_valid_o <= |gnt_vec;
      cmd_o       <= gnt_cmd;
      if (|gnt_vec) begin
        cmd_ba_o  <= gnt_ba;
        cmd_ra_o  <= bk_reqs_i[gnt_ba].ra;
        cmd_ca_o  <= bk_reqs_i[gnt_ba].ca;
        cmd_id_o  <= bk_reqs_i[gnt_ba].id;
        cmd_len_o <= bk_reqs_i[gnt_ba].len;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_req_chk
    a_req_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({bk_reqs_i[b].act_req, bk_reqs_i[b].rd_req,
                bk_reqs_i[b].wr_req, bk_reqs_i[b].pre_req,
                bk_reqs_i[b].ref_req}));
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_vec));

endmodule
